// File: rtl/dds_core.sv
// Direct digital synthesizer. A 32-bit phase accumulator plus a 12-bit phase offset
// address a quarter-wave sine table, giving one 12-bit offset-binary sample per sclk.
module dds_core (
  input  logic        sclk,
  input  logic        rst,
  input  logic        dds_en,
  input  logic [31:0] freq_ctrl,
  input  logic [11:0] phase_ctrl,
  output logic [11:0] dds_data,
  output logic        dds_data_en
);

  localparam int  ROM_DEPTH = 1024;
  localparam int  MAG_W     = 11;
  localparam real PI        = 3.14159265358979323846;

  // The half-step offset makes entry i and its mirror ~i describe points symmetric about
  // the quadrant edge, so folding by bit inversion needs no +1 correction.
  function automatic logic [MAG_W-1:0] quarter_sine(input int i);
    real angle;
    angle = 2.0 * PI * (real'(i) + 0.5) / 4096.0;
    return MAG_W'($rtoi(2047.0 * $sin(angle) + 0.5));
  endfunction

  // Quarter-wave table, evaluated at elaboration; range 2..2047, non-decreasing.
  logic [MAG_W-1:0] sin_rom [ROM_DEPTH];

  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
    localparam logic [MAG_W-1:0] ENTRY = quarter_sine(g);
    assign sin_rom[g] = ENTRY;
  end

  // S0: phase accumulator
  logic [31:0] acc_q, acc_d;
  // S1: summed phase and its valid bit
  logic [11:0] ph_q, ph_d;
  logic        v1_q;
  // S2: table magnitude, quadrant and valid bit
  logic [9:0]       rom_idx;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [1:0]       quad_q;
  logic             v2_q;
  // S3: output sample
  logic [11:0] data_q, data_d;
  logic        data_en_q;

  // NOTE: every variable assigned here gets a value on all paths, so no latch is inferred.
  always_comb begin
    acc_d = dds_en ? acc_q + freq_ctrl : '0;
    ph_d  = acc_q[31:20] + phase_ctrl;
  end

  // Quadrants 1 and 3 walk the table backwards.
  always_comb begin
    rom_idx = ph_q[10] ? ~ph_q[9:0] : ph_q[9:0];
    mag_d   = sin_rom[rom_idx];
  end

  // Positive half-cycle sits above mid-scale, negative half mirrors below it.
  always_comb begin
    data_d = '0;
    if (v2_q) begin
      if (quad_q[1]) data_d = 12'd2047 - {1'b0, mag_q};
      else           data_d = 12'd2048 + {1'b0, mag_q};
    end
  end

  // NOTE: state is updated with non-blocking assignments so every stage samples the
  // previous edge's values of its neighbours, which is what makes this a pipeline.
  // NOTE: the sine table is a constant, not storage, so it has nothing to reset.
  always_ff @(posedge sclk) begin
    if (rst) begin
      acc_q     <= '0;
      ph_q      <= '0;
      v1_q      <= 1'b0;
      mag_q     <= '0;
      quad_q    <= '0;
      v2_q      <= 1'b0;
      data_q    <= '0;
      data_en_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ph_q      <= ph_d;
      v1_q      <= dds_en;
      mag_q     <= mag_d;
      quad_q    <= ph_q[11:10];
      v2_q      <= v1_q;
      data_q    <= data_d;
      data_en_q <= v2_q;
    end
  end

  assign dds_data    = data_q;
  assign dds_data_en = data_en_q;

endmodule

// File: tb/tb_dds_core.sv
// Directed bench for dds_core: reset, quadrant points, phase offset, slow ramp,
// 100 MHz run with a mid-run retune, enable toggle and mid-run reset.
module tb_dds_core;

  logic        sclk;
  logic        rst;
  logic        dds_en;
  logic [31:0] freq_ctrl;
  logic [11:0] phase_ctrl;
  logic [11:0] dds_data;
  logic        dds_data_en;

  int checks;
  int failures;
  int qtab [1024];

  dds_core dut (
    .sclk        (sclk),
    .rst         (rst),
    .dds_en      (dds_en),
    .freq_ctrl   (freq_ctrl),
    .phase_ctrl  (phase_ctrl),
    .dds_data    (dds_data),
    .dds_data_en (dds_data_en)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Reference sample for a 12-bit phase, built from the table definition.
  function automatic logic [11:0] exp_sample(input logic [11:0] ph);
    int i;
    i = int'(ph[9:0]);
    if (ph[10]) i = 1023 - i;
    if (!ph[11]) return 12'(2048 + qtab[i]);
    else         return 12'(2047 - qtab[i]);
  endfunction

  task automatic stop_run();
    dds_en = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dds_en = 1'b1;
    freq_ctrl = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dds_data !== 12'd0 || dds_data_en !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d data=%0d en=%0b want data=0 en=0", i, dds_data, dds_data_en);
      end
    end
    rst = 1'b0;
    dds_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (dds_data !== 12'd0 || dds_data_en !== 1'b0) begin
        failures++;
        $display("FAIL idle cyc=%0d data=%0d en=%0b want data=0 en=0", i, dds_data, dds_data_en);
      end
    end
  endtask

  task automatic test_quadrant();
    logic [11:0] quad_exp [4];
    quad_exp = '{12'd2050, 12'd4095, 12'd2045, 12'd0};
    freq_ctrl = 32'h4000_0000;
    phase_ctrl = 12'd0;
    dds_en = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (dds_data_en !== (e == 3)) begin
        failures++;
        $display("FAIL quad_latency edge=%0d en=%0b want %0b", e, dds_data_en, (e == 3));
      end
    end
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      checks++;
      if (dds_data !== quad_exp[k % 4] || dds_data_en !== 1'b1) begin
        failures++;
        $display("FAIL quad_sample k=%0d data=%0d en=%0b want %0d en=1", k, dds_data, dds_data_en, quad_exp[k % 4]);
      end
    end
    dds_en = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (dds_data_en !== (e < 3)) begin
        failures++;
        $display("FAIL quad_drain edge=%0d en=%0b want %0b", e, dds_data_en, (e < 3));
      end
    end
    checks++;
    if (dds_data !== 12'd0) begin
      failures++;
      $display("FAIL quad_idle_data data=%0d want 0", dds_data);
    end
  endtask

  task automatic test_offset();
    freq_ctrl = 32'd0;
    phase_ctrl = 12'd90;
    dds_en = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dds_data !== 12'd2331 || dds_data_en !== 1'b1) begin
        failures++;
        $display("FAIL offset_steady i=%0d data=%0d en=%0b want 2331 en=1", i, dds_data, dds_data_en);
      end
      tick();
    end
    phase_ctrl = 12'd1024;
    tick();
    tick();
    checks++;
    if (dds_data !== 12'd2331) begin
      failures++;
      $display("FAIL offset_early data=%0d want 2331", dds_data);
    end
    tick();
    checks++;
    if (dds_data !== 12'd4095) begin
      failures++;
      $display("FAIL offset_step data=%0d want 4095", dds_data);
    end
    stop_run();
  endtask

  task automatic test_ramp();
    int prev;
    int mn;
    int mx;
    freq_ctrl = 32'h0010_0000;
    phase_ctrl = 12'd0;
    dds_en = 1'b1;
    repeat (3) tick();
    prev = -1;
    mn = 4096;
    mx = -1;
    for (int n = 0; n < 4100; n++) begin
      checks++;
      if (dds_data !== exp_sample(12'(n)) || dds_data_en !== 1'b1) begin
        failures++;
        $display("FAIL ramp n=%0d data=%0d en=%0b want %0d en=1", n, dds_data, dds_data_en, exp_sample(12'(n)));
      end
      if (n >= 1 && n <= 1023) begin
        checks++;
        if (int'(dds_data) < prev) begin
          failures++;
          $display("FAIL ramp_mono n=%0d data=%0d below prev=%0d", n, dds_data, prev);
        end
      end
      if (n < 4096) begin
        if (int'(dds_data) < mn) mn = int'(dds_data);
        if (int'(dds_data) > mx) mx = int'(dds_data);
      end
      prev = int'(dds_data);
      tick();
    end
    checks++;
    if (mn != 0 || mx != 4095) begin
      failures++;
      $display("FAIL ramp_range min=%0d max=%0d want min=0 max=4095", mn, mx);
    end
    stop_run();
  endtask

  task automatic test_run_100mhz();
    localparam int SWITCH_EDGE = 2001;
    bit [31:0]   f1;
    bit [31:0]   f2;
    bit [31:0]   a;
    bit [31:0]   n;
    logic [11:0] pc;
    logic [11:0] ph;
    f1 = 32'd1000000;
    f2 = 32'd100000;
    freq_ctrl = f1;
    phase_ctrl = 12'd90;
    dds_en = 1'b1;
    for (int k = 1; k < SWITCH_EDGE + 2000; k++) begin
      if (k == SWITCH_EDGE) begin
        freq_ctrl = f2;
        phase_ctrl = 12'd180;
      end
      tick();
      if (k == 3) begin
        checks++;
        if (dds_data !== 12'd2331 || dds_data_en !== 1'b1) begin
          failures++;
          $display("FAIL run_first data=%0d en=%0b want 2331 en=1", dds_data, dds_data_en);
        end
      end
      if (k >= 3) begin
        n = 32'(k - 3);
        if (n + 1 < SWITCH_EDGE) begin
          a = n * f1;
          pc = 12'd90;
        end else begin
          a = 32'(SWITCH_EDGE - 1) * f1 + (n - 32'(SWITCH_EDGE - 1)) * f2;
          pc = 12'd180;
        end
        ph = a[31:20] + pc;
        checks++;
        if (dds_data !== exp_sample(ph) || dds_data_en !== 1'b1) begin
          failures++;
          $display("FAIL run n=%0d data=%0d en=%0b want %0d en=1", n, dds_data, dds_data_en, exp_sample(ph));
        end
      end
    end
    stop_run();
  endtask

  task automatic test_enable_toggle();
    freq_ctrl = 32'h4000_0000;
    phase_ctrl = 12'd0;
    dds_en = 1'b1;
    repeat (8) tick();
    dds_en = 1'b0;
    tick();
    dds_en = 1'b1;
    checks++;
    if (dds_data_en !== 1'b1) begin
      failures++;
      $display("FAIL toggle_d0 en=%0b want 1", dds_data_en);
    end
    tick();
    checks++;
    if (dds_data_en !== 1'b1) begin
      failures++;
      $display("FAIL toggle_d1 en=%0b want 1", dds_data_en);
    end
    tick();
    checks++;
    if (dds_data_en !== 1'b0 || dds_data !== 12'd0) begin
      failures++;
      $display("FAIL toggle_gap data=%0d en=%0b want data=0 en=0", dds_data, dds_data_en);
    end
    tick();
    checks++;
    if (dds_data_en !== 1'b1 || dds_data !== 12'd2050) begin
      failures++;
      $display("FAIL toggle_restart data=%0d en=%0b want 2050 en=1", dds_data, dds_data_en);
    end
    tick();
    checks++;
    if (dds_data !== 12'd4095) begin
      failures++;
      $display("FAIL toggle_next data=%0d want 4095", dds_data);
    end
  endtask

  task automatic test_reset_mid();
    repeat (4) tick();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (dds_data !== 12'd0 || dds_data_en !== 1'b0) begin
        failures++;
        $display("FAIL midrst cyc=%0d data=%0d en=%0b want data=0 en=0", i, dds_data, dds_data_en);
      end
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (dds_data_en !== 1'b0) begin
      failures++;
      $display("FAIL midrst_latency en=%0b want 0", dds_data_en);
    end
    tick();
    checks++;
    if (dds_data_en !== 1'b1 || dds_data !== 12'd2050) begin
      failures++;
      $display("FAIL midrst_restart data=%0d en=%0b want 2050 en=1", dds_data, dds_data_en);
    end
    stop_run();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    dds_en = 1'b0;
    freq_ctrl = 32'd0;
    phase_ctrl = 12'd0;
    for (int i = 0; i < 1024; i++)
      qtab[i] = $rtoi(2047.0 * $sin(2.0 * 3.14159265358979323846 * (real'(i) + 0.5) / 4096.0) + 0.5);

    test_reset();
    test_quadrant();
    test_offset();
    test_ramp();
    test_run_100mhz();
    test_enable_toggle();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
